prv32_alu_unit: RTL and testbench

// - 32-bit integer ALU for the prv32 RISC-V core's execute stage: add/sub, logic, shifts, set-less-than.
// - Produces a result plus cf/zf/vf/sf flags for branch resolution.
// - Result and flags are registered: 1-cycle latency. One clock, synchronous active-low reset.

---
 rtl/prv32_alu_unit_if.sv | 23 ++
 rtl/prv32_alu_unit.sv | 78 +++++++
 tb/tb_prv32_alu_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/prv32_alu_unit_if.sv
// Operand/result bundle between the prv32 execute stage and its ALU.
// The master drives the operands and opcode. The slave returns the registered result and the adder flags.
interface prv32_alu_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [3:0]  alufn;
  logic [31:0] r;
  logic        cf;
  logic        zf;
  logic        vf;
  logic        sf;

  modport master (
    output a, b, shamt, alufn,
    input  r, cf, zf, vf, sf
  );

  modport slave (
    input  a, b, shamt, alufn,
    output r, cf, zf, vf, sf
  );
endinterface

// File: rtl/prv32_alu_unit.sv
// 32-bit prv32 ALU with one shared add/sub adder, a logic unit, shifts and set-less-than.
// The result and the flags are registered, so every operation has a latency of 1 cycle.
module prv32_alu_unit (
  input  logic              clk,
  input  logic              rst_n,
  prv32_alu_unit_if.slave   alu
);

  logic [31:0] op_b;
  logic [32:0] add_full;
  logic [31:0] sum;
  logic        c_next;
  logic        zf_next;
  logic        vf_next;
  logic        sf_next;
  logic [31:0] r_next;

  logic [31:0] r_reg;
  logic        cf_reg;
  logic        zf_reg;
  logic        vf_reg;
  logic        sf_reg;

  // Bit 0 of alufn selects subtract: invert b here and carry the +1 in below.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_opb
      assign op_b[gi] = alu.b[gi] ^ alu.alufn[0];
    end
  endgenerate

  assign add_full = {1'b0, alu.a} + {1'b0, op_b} + {32'd0, alu.alufn[0]};
  assign sum      = add_full[31:0];
  assign c_next   = add_full[32];
  assign zf_next  = (sum == 32'd0);
  assign sf_next  = sum[31];
  assign vf_next  = (alu.a[31] == op_b[31]) && (sum[31] != alu.a[31]);

  always_comb begin
    r_next = 32'd0;
    case (alu.alufn)
      4'b0000, 4'b0001: r_next = sum;
      4'b0011:          r_next = alu.b;
      4'b0100:          r_next = alu.a | alu.b;
      4'b0101:          r_next = alu.a & alu.b;
      4'b0111:          r_next = alu.a ^ alu.b;
      4'b1000:          r_next = alu.a >> alu.shamt;
      4'b1010:          r_next = $unsigned($signed(alu.a) >>> alu.shamt);
      4'b1001:          r_next = alu.a << alu.shamt;
      // The compares use alufn[0]=1, so the adder is already computing a-b.
      4'b1101:          r_next = {31'd0, sf_next != vf_next};
      4'b1111:          r_next = {31'd0, ~c_next};
      default:          r_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg  <= 32'd0;
      cf_reg <= 1'b0;
      zf_reg <= 1'b0;
      vf_reg <= 1'b0;
      sf_reg <= 1'b0;
    end else begin
      r_reg  <= r_next;
      cf_reg <= c_next;
      zf_reg <= zf_next;
      vf_reg <= vf_next;
      sf_reg <= sf_next;
    end
  end

  assign alu.r  = r_reg;
  assign alu.cf = cf_reg;
  assign alu.zf = zf_reg;
  assign alu.vf = vf_reg;
  assign alu.sf = sf_reg;

endmodule

// File: tb/tb_prv32_alu_unit.sv
// Bench for prv32_alu_unit: an arithmetic reference model is checked on every cycle,
// and directed vectors carry hand-computed values that pin both the model and the design.
module tb_prv32_alu_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  prv32_alu_unit_if alu_if ();

  prv32_alu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (alu_if.slave)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, PASS = 4'b0011, OR_ = 4'b0100,
                         AND_ = 4'b0101, XOR_ = 4'b0111, SRL = 4'b1000, SRA = 4'b1010,
                         SLL = 4'b1001, SLT = 4'b1101, SLTU = 4'b1111;

  // Reference model: works on wide signed and unsigned integers instead of a shared adder.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                input logic [3:0] fn, output logic [31:0] r,
                                output logic cf, output logic zf, output logic vf, output logic sf);
    longint          sa, sb, d;
    longint unsigned ua, ub;
    logic [31:0]     s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (fn[0]) begin
      s  = a - b;
      d  = sa - sb;
      cf = (ua >= ub);
    end else begin
      s  = a + b;
      d  = sa + sb;
      cf = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    end
    vf = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    zf = (s == 32'd0);
    sf = s[31];
    case (fn)
      ADD, SUB: r = s;
      PASS:     r = b;
      OR_:      r = a | b;
      AND_:     r = a & b;
      XOR_:     r = a ^ b;
      SRL:      r = 32'(ua / (64'd1 << sh));
      SRA:      r = 32'(sa >>> sh);
      SLL:      r = 32'(ua * (64'd1 << sh));
      SLT:      r = {31'd0, sa < sb};
      SLTU:     r = {31'd0, ua < ub};
      default:  r = 32'd0;
    endcase
  endfunction

  logic [31:0] exp_r;
  logic        exp_cf, exp_zf, exp_vf, exp_sf;
  logic        exp_valid = 1'b0;

  // At each sampling edge, compute the values the outputs must hold after that edge.
  always @(posedge clk) begin
    logic [31:0] mr;
    logic        mc, mz, mv, ms;
    if (!rst_n) begin
      mr = 32'd0; mc = 1'b0; mz = 1'b0; mv = 1'b0; ms = 1'b0;
    end else begin
      model(alu_if.a, alu_if.b, alu_if.shamt, alu_if.alufn, mr, mc, mz, mv, ms);
    end
    exp_r     <= mr;
    exp_cf    <= mc;
    exp_zf    <= mz;
    exp_vf    <= mv;
    exp_sf    <= ms;
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if ({alu_if.r, alu_if.cf, alu_if.zf, alu_if.vf, alu_if.sf} !==
          {exp_r, exp_cf, exp_zf, exp_vf, exp_sf}) begin
        errors++;
        $display("FAIL model_cycle t=%0t got r=%h cf%b zf%b vf%b sf%b want r=%h cf%b zf%b vf%b sf%b",
                 $time, alu_if.r, alu_if.cf, alu_if.zf, alu_if.vf, alu_if.sf,
                 exp_r, exp_cf, exp_zf, exp_vf, exp_sf);
      end
    end
  end

  // Apply one vector and check the result against a hand value; chk_f also checks {cf,zf,vf,sf}.
  task automatic vec(input string name, input logic rn, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [3:0] fn, input logic [31:0] want_r,
                     input logic chk_f, input logic [3:0] want_f);
    @(negedge clk);
    rst_n = rn; alu_if.a = a; alu_if.b = b; alu_if.shamt = sh; alu_if.alufn = fn;
    @(posedge clk);
    #1;
    checks++;
    if (alu_if.r !== want_r ||
        (chk_f && {alu_if.cf, alu_if.zf, alu_if.vf, alu_if.sf} !== want_f)) begin
      errors++;
      $display("FAIL %s got r=%h flags=%b want r=%h flags=%b", name, alu_if.r,
               {alu_if.cf, alu_if.zf, alu_if.vf, alu_if.sf}, want_r, want_f);
    end
    $display("vec %-10s a=%h b=%h sh=%0d fn=%b -> r=%h cf%b zf%b vf%b sf%b", name, a, b, sh, fn,
             alu_if.r, alu_if.cf, alu_if.zf, alu_if.vf, alu_if.sf);
  endtask

  initial begin
    logic [31:0] ops [4];
    rst_n = 1'b0;
    alu_if.a = 32'd0; alu_if.b = 32'd0; alu_if.shamt = 5'd0; alu_if.alufn = ADD;
    @(posedge clk);
    vec("reset",    1'b0, 32'd5, 32'd7, 5'd0, ADD, 32'd0, 1'b1, 4'b0000);
    vec("rel_add",  1'b1, 32'd5, 32'd7, 5'd0, ADD, 32'd12, 1'b0, 4'b0000);
    vec("add",      1'b1, 32'd32, 32'd100, 5'd0, ADD, 32'd132, 1'b0, 4'b0000);
    vec("sub",      1'b1, 32'd32, 32'd100, 5'd0, SUB, 32'hFFFF_FFBC, 1'b1, 4'b0001);
    vec("pass",     1'b1, 32'd32, 32'd100, 5'd0, PASS, 32'd100, 1'b0, 4'b0000);
    vec("or",       1'b1, 32'h2A, 32'h15, 5'd0, OR_, 32'h3F, 1'b0, 4'b0000);
    vec("and",      1'b1, 32'h2A, 32'h15, 5'd0, AND_, 32'h0, 1'b0, 4'b0000);
    vec("xor",      1'b1, 32'h2A, 32'h15, 5'd0, XOR_, 32'h3F, 1'b0, 4'b0000);
    vec("srl1",     1'b1, 32'd255, 32'd0, 5'd1, SRL, 32'd127, 1'b0, 4'b0000);
    vec("sra5",     1'b1, 32'd255, 32'd0, 5'd5, SRA, 32'd7, 1'b0, 4'b0000);
    vec("sll2",     1'b1, 32'd255, 32'd0, 5'd2, SLL, 32'd1020, 1'b0, 4'b0000);
    vec("sra_neg",  1'b1, 32'h8000_0000, 32'd0, 5'd4, SRA, 32'hF800_0000, 1'b0, 4'b0000);
    vec("sll0",     1'b1, 32'hDEAD_BEEF, 32'd9, 5'd0, SLL, 32'hDEAD_BEEF, 1'b0, 4'b0000);
    vec("sra0",     1'b1, 32'h8000_0001, 32'd9, 5'd0, SRA, 32'h8000_0001, 1'b0, 4'b0000);
    vec("srl31",    1'b1, 32'h8000_0000, 32'd0, 5'd31, SRL, 32'd1, 1'b0, 4'b0000);
    vec("slt",      1'b1, 32'd1, 32'hFFFF_FFFF, 5'd0, SLT, 32'd0, 1'b0, 4'b0000);
    vec("sltu",     1'b1, 32'd1, 32'hFFFF_FFFF, 5'd0, SLTU, 32'd1, 1'b0, 4'b0000);
    vec("slt_neg",  1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, SLT, 32'd1, 1'b0, 4'b0000);
    vec("add_ovf",  1'b1, 32'h8000_0000, 32'h8000_0000, 5'd0, ADD, 32'd0, 1'b1, 4'b1110);
    vec("sub_eq",   1'b1, 32'd77, 32'd77, 5'd0, SUB, 32'd0, 1'b1, 4'b1100);
    vec("sub_ovf",  1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, SUB, 32'h8000_0000, 1'b1, 4'b0011);
    vec("undef0110",1'b1, 32'd5, 32'd3, 5'd0, 4'b0110, 32'd0, 1'b0, 4'b0000);
    vec("rst_win",  1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, ADD, 32'd0, 1'b1, 4'b0000);
    // Sweep every opcode over a few operand pairs; here the per-cycle model does the checking.
    ops[0] = 32'h0000_0000; ops[1] = 32'h7FFF_FFFF; ops[2] = 32'h8000_0000; ops[3] = 32'hA5A5_1234;
    for (int fn = 0; fn < 16; fn++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        rst_n = 1'b1;
        alu_if.a = ops[i];
        alu_if.b = ops[(i + fn) % 4] ^ 32'(fn);
        alu_if.shamt = 5'(fn * 3 + i);
        alu_if.alufn = 4'(fn);
      end
    end
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
